// File: rtl/hdp_pkg.sv
// Shared constants, FSM state encodings and power-up table for the HDP SPI command sequencer.
package hdp_pkg;
  localparam int WORD_WIDTH       = 8;
  localparam int ADDR_WIDTH       = 7;
  localparam int RW_BIT           = 7;
  localparam int DEF_INIT_LEN     = 8;
  localparam int DEF_BUSY_TIMEOUT = 4096;
  localparam int DEF_POST_GAP     = 64;
  localparam int ROM_DEPTH        = 8;

  localparam logic [2:0] ST_INIT_FETCH = 3'd0;
  localparam logic [2:0] ST_ISSUE      = 3'd1;
  localparam logic [2:0] ST_WAIT_HI    = 3'd2;
  localparam logic [2:0] ST_WAIT_LO    = 3'd3;
  localparam logic [2:0] ST_GAP        = 3'd4;
  localparam logic [2:0] ST_IDLE       = 3'd5;
  localparam logic [2:0] ST_RESPOND    = 3'd6;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] data;
  } init_entry_t;

  localparam init_entry_t INIT_TABLE [ROM_DEPTH] = '{
    '{7'h01, 8'h80}, '{7'h02, 8'h11}, '{7'h03, 8'h22}, '{7'h10, 8'h05},
    '{7'h11, 8'h0F}, '{7'h20, 8'hA0}, '{7'h21, 8'h3C}, '{7'h30, 8'h01}
  };

  function automatic logic [WORD_WIDTH-1:0] make_upper(input logic rw,
                                                       input logic [ADDR_WIDTH-1:0] addr);
    logic [WORD_WIDTH-1:0] v;
    v = '0;
    v[ADDR_WIDTH-1:0] = addr;
    v[RW_BIT] = rw;
    return v;
  endfunction
endpackage

// File: rtl/hdp_init_rom.sv
// Power-up register write table: index -> {addr, data}; out-of-range indices read as zero.
module hdp_init_rom
  import hdp_pkg::*;
#(
  parameter int INIT_LEN = DEF_INIT_LEN,
  parameter int IDX_W    = 4
)(
  input  logic [IDX_W-1:0] i_idx,
  output init_entry_t      o_entry
);
  always_comb begin
    o_entry = '0;
    for (int k = 0; k < ROM_DEPTH; k++) begin
      if (k < INIT_LEN && i_idx == IDX_W'(k)) o_entry = INIT_TABLE[k];
    end
  end
endmodule

// File: rtl/hdp_spi_cmd_sequencer.sv
// Sequences power-up register writes, then host read/write commands, onto an SPI master
// using start/busy handshaking with per-phase busy timeouts and a fixed post-transfer gap.
//
// state         | meaning
// INIT_FETCH    | load next power-up entry or finish init
// ISSUE         | first cycle of spi_start
// WAIT_HI       | spi_start held until busy_s rises
// WAIT_LO       | wait for busy_s to fall, then capture rx byte
// GAP           | POST_GAP idle cycles between transfers
// IDLE          | accept host commands
// RESPOND       | one-cycle response pulse
module hdp_spi_cmd_sequencer
  import hdp_pkg::*;
#(
  parameter int WORD_WIDTH   = hdp_pkg::WORD_WIDTH,
  parameter int INIT_LEN     = DEF_INIT_LEN,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int POST_GAP     = DEF_POST_GAP
)(
  input  logic                  i_sys_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_rw,
  input  logic [6:0]            i_cmd_addr,
  input  logic [WORD_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_rsp_valid,
  output logic [WORD_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_error,
  output logic                  o_init_done,
  output logic                  o_init_fail,
  output logic                  o_spi_enable,
  output logic                  o_spi_start,
  output logic [WORD_WIDTH-1:0] o_spi_tx_upper,
  output logic [WORD_WIDTH-1:0] o_spi_tx_lower,
  input  logic                  i_spi_busy,
  input  logic [WORD_WIDTH-1:0] i_spi_rx_lower
);
  localparam int IDX_W = $clog2(INIT_LEN + 1);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int GAP_W = $clog2(POST_GAP + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(BUSY_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POST_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(INIT_LEN);

  logic [2:0]            r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [TMO_W-1:0]      r_tmo;
  logic [GAP_W-1:0]      r_gap;
  logic                  r_busy_m, r_busy_s;
  logic                  r_host, r_tmo_hit, r_init_done, r_init_fail;
  logic [WORD_WIDTH-1:0] r_tx_upper, r_tx_lower, r_rx, r_rsp_rdata;
  init_entry_t           w_rom;
  logic                  w_run, w_rsp_valid;

  hdp_init_rom #(.INIT_LEN(INIT_LEN), .IDX_W(IDX_W)) u_rom (
    .i_idx   (r_idx),
    .o_entry (w_rom)
  );

  // Decoded outputs are gated by reset so an in-flight spi_start drops within the reset cycle.
  assign w_run          = !i_reset;
  assign w_rsp_valid    = w_run && (r_state == ST_RESPOND);
  assign o_spi_enable   = w_run;
  assign o_spi_start    = w_run && (r_state == ST_ISSUE || r_state == ST_WAIT_HI);
  assign o_cmd_ready    = w_run && (r_state == ST_IDLE) && r_init_done;
  assign o_rsp_valid    = w_rsp_valid;
  assign o_rsp_error    = w_rsp_valid && r_tmo_hit;
  assign o_rsp_rdata    = r_rsp_rdata;
  assign o_init_done    = r_init_done;
  assign o_init_fail    = r_init_fail;
  assign o_spi_tx_upper = r_tx_upper;
  assign o_spi_tx_lower = r_tx_lower;

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_state     <= ST_INIT_FETCH;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_gap       <= '0;
      r_busy_m    <= 1'b0;
      r_busy_s    <= 1'b0;
      r_host      <= 1'b0;
      r_tmo_hit   <= 1'b0;
      r_init_done <= 1'b0;
      r_init_fail <= 1'b0;
      r_tx_upper  <= '0;
      r_tx_lower  <= '0;
      r_rx        <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_busy_m <= i_spi_busy;
      r_busy_s <= r_busy_m;
      case (r_state)
        ST_INIT_FETCH: begin
          if (r_idx == IDX_END) begin
            r_init_done <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_tx_upper <= make_upper(1'b0, w_rom.addr);
            r_tx_lower <= w_rom.data;
            r_host     <= 1'b0;
            r_tmo_hit  <= 1'b0;
            r_tmo      <= TMO_LOAD;
            r_state    <= ST_ISSUE;
          end
        end
        ST_IDLE: begin
          if (i_cmd_valid && r_init_done) begin
            r_tx_upper <= make_upper(i_cmd_rw, i_cmd_addr);
            r_tx_lower <= i_cmd_rw ? '0 : i_cmd_wdata;
            r_host     <= 1'b1;
            r_tmo_hit  <= 1'b0;
            r_tmo      <= TMO_LOAD;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_tmo   <= r_tmo - 1'b1;
          r_state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (r_busy_s) begin
            r_tmo   <= TMO_LOAD;
            r_state <= ST_WAIT_LO;
          end else if (r_tmo == '0) begin
            r_tmo_hit <= 1'b1;
            if (!r_host) r_init_fail <= 1'b1;
            r_gap   <= GAP_LOAD;
            r_state <= ST_GAP;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!r_busy_s) begin
            r_rx    <= i_spi_rx_lower;
            r_gap   <= GAP_LOAD;
            r_state <= ST_GAP;
          end else if (r_tmo == '0) begin
            r_tmo_hit <= 1'b1;
            if (!r_host) r_init_fail <= 1'b1;
            r_gap   <= GAP_LOAD;
            r_state <= ST_GAP;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap == '0) begin
            if (r_host) begin
              r_rsp_rdata <= (r_tx_upper[RW_BIT] && !r_tmo_hit) ? r_rx : '0;
              r_state     <= ST_RESPOND;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_INIT_FETCH;
            end
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        ST_RESPOND: r_state <= ST_IDLE;
        default:    r_state <= ST_INIT_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_hdp_spi_cmd_sequencer.sv
// Directed bench for hdp_spi_cmd_sequencer with a behavioural SPI busy/rx responder.
module tb_hdp_spi_cmd_sequencer;
  localparam int POST_GAP     = 64;
  localparam int BUSY_TIMEOUT = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       spi_busy = 1'b0;
  logic [7:0] spi_rx = '0;
  logic       o_cmd_ready, o_rsp_valid, o_rsp_error, o_init_done, o_init_fail;
  logic       o_spi_enable, o_spi_start;
  logic [7:0] o_rsp_rdata, o_spi_tx_upper, o_spi_tx_lower;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [6:0] rom_addr [8] = '{7'h01, 7'h02, 7'h03, 7'h10, 7'h11, 7'h20, 7'h21, 7'h30};
  logic [7:0] rom_data [8] = '{8'h80, 8'h11, 8'h22, 8'h05, 8'h0F, 8'hA0, 8'h3C, 8'h01};

  // SPI responder: 0 normal, 1 never raises busy, 2 busy stuck on transfer number stuck_idx
  int         model_mode = 0;
  int         stuck_idx  = 3;
  int         hold_norm  = 5;
  logic [7:0] model_rx   = '0;
  int         drop_cyc   = 0;
  logic [7:0] log_up [$];
  logic [7:0] log_lo [$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hdp_spi_cmd_sequencer dut (
    .i_sys_clk      (clk),
    .i_reset        (rst),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_rw       (cmd_rw),
    .i_cmd_addr     (cmd_addr),
    .i_cmd_wdata    (cmd_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_error    (o_rsp_error),
    .o_init_done    (o_init_done),
    .o_init_fail    (o_init_fail),
    .o_spi_enable   (o_spi_enable),
    .o_spi_start    (o_spi_start),
    .o_spi_tx_upper (o_spi_tx_upper),
    .o_spi_tx_lower (o_spi_tx_lower),
    .i_spi_busy     (spi_busy),
    .i_spi_rx_lower (spi_rx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : spi_model
    forever begin
      int hold;
      @(posedge clk);
      #1;
      if (!rst && o_spi_start && model_mode != 1) begin
        hold = (model_mode == 2 && log_up.size() == stuck_idx) ? 4110 : hold_norm;
        log_up.push_back(o_spi_tx_upper);
        log_lo.push_back(o_spi_tx_lower);
        for (int k = 0; k < 2; k++) begin @(posedge clk); #1; end
        spi_busy = 1'b1;
        for (int k = 0; k < hold && !rst; k++) begin @(posedge clk); #1; end
        if (hold == hold_norm && !rst && log_up.size() > 0) begin
          checks++;
          if (o_spi_tx_upper !== log_up[log_up.size()-1]) begin
            errors++;
            $display("FAIL tx_upper_stable: got %h required %h", o_spi_tx_upper, log_up[log_up.size()-1]);
          end
        end
        spi_rx   = model_rx;
        spi_busy = 1'b0;
        drop_cyc = cyc;
      end
    end
  end

  task automatic send_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                          output logic ok);
    int n = 0;
    while (!o_cmd_ready && n < 20000) begin tick(); n++; end
    ok = o_cmd_ready;
    if (ok) begin
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd;
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output logic ok, output int rcyc, output logic [7:0] rd,
                          output logic er, output logic next_valid);
    int n = 0;
    while (!o_rsp_valid && n < 6000) begin tick(); n++; end
    ok = o_rsp_valid; rcyc = cyc; rd = o_rsp_rdata; er = o_rsp_error;
    tick();
    next_valid = o_rsp_valid;
  endtask

  task automatic wait_init(output logic ok, output logic early);
    int n = 0;
    early = 1'b0;
    while (!o_init_done && n < 25000) begin
      if (o_cmd_ready) early = 1'b1;
      tick(); n++;
    end
    ok = o_init_done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (o_spi_start !== 1'b0)  begin errors++; $display("FAIL rst_spi_start: got %b required 0", o_spi_start); end
    checks++; if (o_cmd_ready !== 1'b0)  begin errors++; $display("FAIL rst_cmd_ready: got %b required 0", o_cmd_ready); end
    checks++; if (o_rsp_valid !== 1'b0)  begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", o_rsp_valid); end
    checks++; if (o_rsp_error !== 1'b0)  begin errors++; $display("FAIL rst_rsp_error: got %b required 0", o_rsp_error); end
    checks++; if (o_init_done !== 1'b0)  begin errors++; $display("FAIL rst_init_done: got %b required 0", o_init_done); end
    checks++; if (o_init_fail !== 1'b0)  begin errors++; $display("FAIL rst_init_fail: got %b required 0", o_init_fail); end
    checks++; if (o_spi_enable !== 1'b0) begin errors++; $display("FAIL rst_spi_enable: got %b required 0", o_spi_enable); end
    checks++; if (o_spi_tx_upper !== 8'h00) begin errors++; $display("FAIL rst_tx_upper: got %h required 00", o_spi_tx_upper); end
    checks++; if (o_spi_tx_lower !== 8'h00) begin errors++; $display("FAIL rst_tx_lower: got %h required 00", o_spi_tx_lower); end
    checks++; if (o_rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rsp_rdata: got %h required 00", o_rsp_rdata); end
  endtask

  task automatic check_init_log(input string tag);
    checks++;
    if (log_up.size() !== 8) begin errors++; $display("FAIL %s_count: got %0d required 8", tag, log_up.size()); end
    for (int k = 0; k < 8; k++) begin
      if (k < log_up.size()) begin
        checks++;
        if (log_up[k] !== {1'b0, rom_addr[k]}) begin
          errors++; $display("FAIL %s_upper%0d: got %h required %h", tag, k, log_up[k], {1'b0, rom_addr[k]});
        end
        checks++;
        if (log_lo[k] !== rom_data[k]) begin
          errors++; $display("FAIL %s_lower%0d: got %h required %h", tag, k, log_lo[k], rom_data[k]);
        end
      end
    end
  endtask

  task automatic test_init();
    logic ok, early1, early2;
    log_up.delete(); log_lo.delete();
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h55; cmd_wdata = 8'hEE;
    rst = 1'b0;
    #1;
    checks++; if (o_spi_enable !== 1'b1) begin errors++; $display("FAIL init_spi_enable: got %b required 1", o_spi_enable); end
    early1 = 1'b0;
    repeat (100) begin
      if (o_cmd_ready) early1 = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    wait_init(ok, early2);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL init_done_wait: got %b required 1", ok); end
    checks++; if ((early1 | early2) !== 1'b0) begin errors++; $display("FAIL init_ready_early: got 1 required 0"); end
    checks++; if (o_init_fail !== 1'b0) begin errors++; $display("FAIL init_fail_clean: got %b required 0", o_init_fail); end
    checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL init_ready_after: got %b required 1", o_cmd_ready); end
    check_init_log("init");
  endtask

  task automatic test_read();
    logic ok, rok, er, nv; int rc; logic [7:0] rd;
    model_rx = 8'hA5;
    send_cmd(1'b1, 7'h12, 8'h99, ok);
    wait_rsp(rok, rc, rd, er, nv);
    checks++; if ((ok & rok) !== 1'b1) begin errors++; $display("FAIL read_handshake: got %b%b required 11", ok, rok); end
    checks++; if (log_up[log_up.size()-1] !== 8'h92) begin errors++; $display("FAIL read_tx_upper: got %h required 92", log_up[log_up.size()-1]); end
    checks++; if (log_lo[log_lo.size()-1] !== 8'h00) begin errors++; $display("FAIL read_tx_lower: got %h required 00", log_lo[log_lo.size()-1]); end
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h required a5", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_error: got %b required 0", er); end
    checks++; if (nv !== 1'b0) begin errors++; $display("FAIL read_pulse_width: got %b required 0", nv); end
  endtask

  task automatic test_write();
    logic ok, rok, er, nv; int rc; logic [7:0] rd;
    model_rx = 8'h77;
    send_cmd(1'b0, 7'h05, 8'h3C, ok);
    wait_rsp(rok, rc, rd, er, nv);
    checks++; if ((ok & rok) !== 1'b1) begin errors++; $display("FAIL write_handshake: got %b%b required 11", ok, rok); end
    checks++; if (log_up[log_up.size()-1] !== 8'h05) begin errors++; $display("FAIL write_tx_upper: got %h required 05", log_up[log_up.size()-1]); end
    checks++; if (log_lo[log_lo.size()-1] !== 8'h3C) begin errors++; $display("FAIL write_tx_lower: got %h required 3c", log_lo[log_lo.size()-1]); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL write_rdata: got %h required 00", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL write_error: got %b required 0", er); end
    checks++; if (nv !== 1'b0) begin errors++; $display("FAIL write_pulse_width: got %b required 0", nv); end
    // busy pin -> busy_s takes 2 edges, then POST_GAP+1 more edges to the response
    checks++;
    if (rc - drop_cyc !== POST_GAP + 3) begin
      errors++; $display("FAIL write_latency: got %0d required %0d", rc - drop_cyc, POST_GAP + 3);
    end
  endtask

  task automatic test_timeout();
    logic ok, rok, er, nv; int rc, n, n0; logic [7:0] rd;
    model_mode = 1;
    model_rx = 8'hC3;
    n0 = log_up.size();
    send_cmd(1'b1, 7'h12, 8'h00, ok);
    n = 0;
    while (o_spi_start && n < 5000) begin n++; tick(); end
    checks++; if (n !== BUSY_TIMEOUT) begin errors++; $display("FAIL tmo_start_len: got %0d required %0d", n, BUSY_TIMEOUT); end
    wait_rsp(rok, rc, rd, er, nv);
    checks++; if ((ok & rok) !== 1'b1) begin errors++; $display("FAIL tmo_handshake: got %b%b required 11", ok, rok); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b required 1", er); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL tmo_rdata: got %h required 00", rd); end
    checks++; if (log_up.size() !== n0) begin errors++; $display("FAIL tmo_no_xfer: got %0d required %0d", log_up.size(), n0); end
    model_mode = 0;
    model_rx = 8'h5A;
    send_cmd(1'b1, 7'h21, 8'h00, ok);
    wait_rsp(rok, rc, rd, er, nv);
    checks++; if (log_up[log_up.size()-1] !== 8'hA1) begin errors++; $display("FAIL after_tmo_upper: got %h required a1", log_up[log_up.size()-1]); end
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL after_tmo_rdata: got %h required 5a", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL after_tmo_error: got %b required 0", er); end
  endtask

  task automatic test_init_timeout();
    logic ok, early, sok, rok, er, nv; int rc; logic [7:0] rd;
    model_mode = 2;
    stuck_idx = 3;
    rst = 1'b1;
    repeat (5) tick();
    log_up.delete(); log_lo.delete();
    rst = 1'b0;
    wait_init(ok, early);
    model_mode = 0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL itmo_done: got %b required 1", ok); end
    checks++; if (o_init_fail !== 1'b1) begin errors++; $display("FAIL itmo_fail: got %b required 1", o_init_fail); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL itmo_ready_early: got 1 required 0"); end
    check_init_log("itmo");
    send_cmd(1'b0, 7'h07, 8'h01, sok);
    wait_rsp(rok, rc, rd, er, nv);
    checks++; if ((sok & rok) !== 1'b1) begin errors++; $display("FAIL itmo_cmd: got %b%b required 11", sok, rok); end
    checks++; if (o_init_fail !== 1'b1) begin errors++; $display("FAIL itmo_fail_sticky: got %b required 1", o_init_fail); end
  endtask

  task automatic test_reset_mid_transfer();
    logic ok, early; int n;
    send_cmd(1'b0, 7'h05, 8'h3C, ok);
    checks++; if (o_spi_start !== 1'b1) begin errors++; $display("FAIL issue_start: got %b required 1", o_spi_start); end
    rst = 1'b1;
    #1;
    checks++; if (o_spi_start !== 1'b0) begin errors++; $display("FAIL issue_rst_start: got %b required 0", o_spi_start); end
    repeat (5) tick();
    log_up.delete(); log_lo.delete();
    rst = 1'b0;
    wait_init(ok, early);
    checks++; if ((ok & !early) !== 1'b1) begin errors++; $display("FAIL issue_reinit: done %b early %b required 1 0", ok, early); end
    checks++; if (log_up.size() > 0 && log_up[0] !== 8'h01) begin errors++; $display("FAIL issue_entry0: got %h required 01", log_up[0]); end

    hold_norm = 40;
    send_cmd(1'b1, 7'h12, 8'h00, ok);
    n = 0;
    while (!spi_busy && n < 100) begin tick(); n++; end
    checks++; if (spi_busy !== 1'b1) begin errors++; $display("FAIL lo_busy_seen: got %b required 1", spi_busy); end
    repeat (5) tick();
    rst = 1'b1;
    #1;
    checks++; if (o_spi_start !== 1'b0) begin errors++; $display("FAIL lo_rst_start: got %b required 0", o_spi_start); end
    checks++; if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL lo_rst_ready: got %b required 0", o_cmd_ready); end
    tick();
    checks++; if (o_init_done !== 1'b0) begin errors++; $display("FAIL lo_rst_done: got %b required 0", o_init_done); end
    hold_norm = 5;
    repeat (5) tick();
    log_up.delete(); log_lo.delete();
    rst = 1'b0;
    wait_init(ok, early);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lo_reinit_done: got %b required 1", ok); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL lo_ready_early: got 1 required 0"); end
    checks++; if (o_init_fail !== 1'b0) begin errors++; $display("FAIL lo_init_fail: got %b required 0", o_init_fail); end
    check_init_log("lo_reinit");
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_write();
    test_timeout();
    test_init_timeout();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
